hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-002 Port clk SHALL be input, 1 bit, the system clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be input, 1 bit, the asynchronous active-high reset.
REQ-004 Port src1_id SHALL be input, 5 bits, the first source register of the instruction in ID.
REQ-005 Port src2_id SHALL be input, 5 bits, the second source register of the instruction in ID.
REQ-006 Port two_src_id SHALL be input, 1 bit; when high, src2_id is a real operand (R-type or store).
REQ-007 Port ex_dest, ex_wb_en and ex_mem_r_en SHALL be inputs of 5, 1 and 1 bits, taken from the ID/EX register outputs.
REQ-008 Port mem_dest and mem_wb_en SHALL be inputs of 5 and 1 bits, taken from the EX/MEM register outputs.
REQ-009 Port br_taken SHALL be input, 1 bit, the branch-taken signal resolved in EX.
REQ-010 Port freeze SHALL be output, 1 bit; it holds the PC and the IF/ID register.
REQ-011 Port ifid_flush SHALL be output, 1 bit; it clears the IF/ID register.
REQ-012 Port idex_bubble SHALL be output, 1 bit; it forces the ID/EX inputs MEM_R_EN, MEM_W_EN, WB_EN and brTaken to 0.
REQ-013 Port state SHALL be output, 2 bits, carrying the FSM state encoding.
REQ-014 Ports stall_cnt and flush_cnt SHALL be outputs, 16 bits each, carrying the performance counters.

Function
REQ-015 The FSM SHALL have three states: RUN=2'b00, STALL=2'b01 and FLUSH=2'b10; the encoding 2'b11 SHALL return to RUN on the next clock.
REQ-016 A source-register match SHALL require a nonzero register number; a match on R0 SHALL never raise a hazard.
REQ-017 The src2_id operand SHALL participate in matching only when two_src_id=1.
REQ-018 The hazard signal SHALL be computed combinationally from the current inputs, so that freeze and idex_bubble are asserted in the same cycle the hazard is present.
REQ-019 The outputs freeze=1 and idex_bubble=1 SHALL be asserted whenever hazard=1 and br_taken=0; ifid_flush SHALL stay 0 in that case.
REQ-020 When br_taken=1 in RUN or STALL, the block SHALL assert ifid_flush=1 and idex_bubble=1, hold freeze=0, and move to FLUSH.
REQ-021 In FLUSH, the block SHALL assert ifid_flush=1 and idex_bubble=1 for exactly one cycle, ignore both hazard and br_taken, and then move to RUN.
REQ-022 From RUN, the FSM SHALL move to STALL when hazard=1 and br_taken=0.
REQ-023 From STALL, the FSM SHALL move to RUN when hazard=0, and to FLUSH when br_taken=1.
REQ-024 When hazard and br_taken are both 1, the branch SHALL win: no freeze, and the transition goes to FLUSH.
REQ-025 stall_cnt SHALL increment in every cycle with freeze=1.
REQ-026 flush_cnt SHALL increment in every cycle with ifid_flush=1.
REQ-027 Both counters SHALL saturate at 16'hFFFF and never wrap.

Reset
REQ-028 While rst=1, the block SHALL hold state=RUN, stall_cnt=0 and flush_cnt=0, asynchronously and including in the middle of a STALL or FLUSH.
REQ-029 While rst=1, the outputs freeze, ifid_flush and idex_bubble SHALL all be forced to 0.

Configuration
REQ-030 When FORWARD_EN is defined, the hazard SHALL be defined as ex_mem_r_en & ex_wb_en & (a src match to ex_dest), covering only load-use cases; mem_dest and mem_wb_en SHALL be ignored.
REQ-031 When FORWARD_EN is not defined, the hazard SHALL be defined as (ex_wb_en & a src match to ex_dest) | (mem_wb_en & a src match to mem_dest).

Verification
REQ-032 Scenario: with FORWARD_EN defined, ex_mem_r_en=1, ex_wb_en=1, ex_dest=5, src1_id=5 held for 1 cycle -> freeze=1 and idex_bubble=1 that cycle, state becomes STALL and then RUN, and stall_cnt=1.
REQ-033 Scenario: with FORWARD_EN not defined, mem_wb_en=1, mem_dest=7, src2_id=7 and two_src_id=0 -> no hazard; repeating with two_src_id=1 -> freeze=1.
REQ-034 Scenario: br_taken=1 together with an active hazard -> freeze=0 and ifid_flush=1 for 2 consecutive cycles, and flush_cnt=2.
REQ-035 Scenario: src1_id=0, ex_dest=0, ex_wb_en=1 and ex_mem_r_en=1 -> no hazard under either configuration.
REQ-036 Scenario: rst asserted asynchronously mid-FLUSH -> outputs drop to 0 immediately, and state=RUN with both counters at 0.
REQ-037 Scenario: stall_cnt preloaded to 16'hFFFE and then 3 stall cycles -> stall_cnt reads 16'hFFFF and holds there.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use/RAW stall detection, branch flush FSM and saturating perf counters.
// Build option: define FORWARD_EN to restrict stalls to load-use hazards on the ID/EX stage only.
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  src1_id,
    input  logic [4:0]  src2_id,
    input  logic        two_src_id,
    input  logic [4:0]  ex_dest,
    input  logic        ex_wb_en,
    input  logic        ex_mem_r_en,
    input  logic [4:0]  mem_dest,
    input  logic        mem_wb_en,
    input  logic        br_taken,
    output logic        freeze,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        STALL   = 2'b01,
        FLUSH   = 2'b10,
        ILLEGAL = 2'b11
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_hazard;
    logic        w_freeze;
    logic        w_flush;
    logic        w_bubble;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    // R0 is hardwired to zero, so a match on it is never a dependency.
    function automatic logic src_match(input logic [4:0] s1, input logic [4:0] s2,
                                       input logic two, input logic [4:0] dest);
        return (dest != 5'd0) && ((s1 == dest) || (two && (s2 == dest)));
    endfunction

`ifdef FORWARD_EN
    logic w_unused_mem;
    assign w_unused_mem = ^{mem_dest, mem_wb_en};
    assign w_hazard = ex_mem_r_en & ex_wb_en & src_match(src1_id, src2_id, two_src_id, ex_dest);
`else
    assign w_hazard = (ex_wb_en  & src_match(src1_id, src2_id, two_src_id, ex_dest)) |
                      (mem_wb_en & src_match(src1_id, src2_id, two_src_id, mem_dest));
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and raw control outputs; a taken branch always beats a stall.
    always_comb begin
        w_next   = RUN;
        w_freeze = 1'b0;
        w_flush  = 1'b0;
        w_bubble = 1'b0;
        case (r_state)
            RUN, STALL: begin
                if (br_taken) begin
                    w_flush  = 1'b1;
                    w_bubble = 1'b1;
                    w_next   = FLUSH;
                end else if (w_hazard) begin
                    w_freeze = 1'b1;
                    w_bubble = 1'b1;
                    w_next   = STALL;
                end else begin
                    w_next   = RUN;
                end
            end
            FLUSH: begin
                w_flush  = 1'b1;
                w_bubble = 1'b1;
                w_next   = RUN;
            end
            default: begin
                w_next = RUN;
            end
        endcase
    end

    // Outputs are forced quiet for the whole reset window, not just at the edge.
    always_comb begin
        if (rst) begin
            freeze      = 1'b0;
            ifid_flush  = 1'b0;
            idex_bubble = 1'b0;
        end else begin
            freeze      = w_freeze;
            ifid_flush  = w_flush;
            idex_bubble = w_bubble;
        end
    end

    // Saturating stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= 16'd0;
        end else if (w_freeze && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    // Saturating flush counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush_cnt <= 16'd0;
        end else if (w_flush && (r_flush_cnt != 16'hFFFF)) begin
            r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign state     = r_state;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table through a scoreboard queue plus corner-case sequences.
module tb_hazard_ctrl;

`ifdef FORWARD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif
    localparam logic NF = ~FWD;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  src1_id, src2_id, ex_dest, mem_dest;
    logic        two_src_id, ex_wb_en, ex_mem_r_en, mem_wb_en, br_taken;
    logic        freeze, ifid_flush, idex_bubble;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [4:0] s1, s2;
        logic       two;
        logic [4:0] exd;
        logic       exwb, exmr;
        logic [4:0] memd;
        logic       memwb, br;
        logic       e_frz, e_fl, e_bub;
        logic [1:0] e_st;
    } vec_t;

    typedef struct {
        logic       e_frz, e_fl, e_bub;
        logic [1:0] e_st;
        int         idx;
    } exp_t;

    vec_t vecs[17];
    exp_t sb[$];

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .src1_id(src1_id), .src2_id(src2_id), .two_src_id(two_src_id),
        .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .br_taken(br_taken),
        .freeze(freeze), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] s1, input logic [4:0] s2, input logic two,
                                input logic [4:0] exd, input logic exwb, input logic exmr,
                                input logic [4:0] memd, input logic memwb, input logic br,
                                input logic f, input logic fl, input logic b, input logic [1:0] st);
        vec_t v;
        v.s1 = s1; v.s2 = s2; v.two = two; v.exd = exd; v.exwb = exwb; v.exmr = exmr;
        v.memd = memd; v.memwb = memwb; v.br = br;
        v.e_frz = f; v.e_fl = fl; v.e_bub = b; v.e_st = st;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        src1_id = v.s1; src2_id = v.s2; two_src_id = v.two; ex_dest = v.exd;
        ex_wb_en = v.exwb; ex_mem_r_en = v.exmr; mem_dest = v.memd; mem_wb_en = v.memwb;
        br_taken = v.br;
    endtask

    task automatic idle();
        drive(mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
    endtask

    task automatic load_use(input logic br);
        drive(mk(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, br, 1'b0, 1'b0, 1'b0, 2'd0));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        exp_t e;
        rst = 1'b1;
        load_use(1'b1);
        // Rows: s1 s2 two exd exwb exmr memd memwb br | freeze flush bubble state
        vecs[0]  = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        vecs[1]  = mk(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
        vecs[2]  = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01);
        vecs[3]  = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        vecs[4]  = mk(5'd1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        vecs[5]  = mk(5'd1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, NF,   1'b0, NF,   2'b00);
        vecs[6]  = mk(5'd1, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, NF,   1'b0, NF,   {1'b0, NF});
        vecs[7]  = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, {1'b0, NF});
        vecs[8]  = mk(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00);
        vecs[9]  = mk(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10);
        vecs[10] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        vecs[11] = mk(5'd1, 5'd9, 1'b0, 5'd9, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        vecs[12] = mk(5'd4, 5'd0, 1'b0, 5'd4, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        vecs[13] = mk(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
        vecs[14] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01);
        vecs[15] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10);
        vecs[16] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);

        // Reset holds outputs low even with a hazard and branch on the inputs.
        @(negedge clk);
        chk("rst_freeze", {31'd0, freeze}, 32'd0);
        chk("rst_flush", {31'd0, ifid_flush}, 32'd0);
        chk("rst_bubble", {31'd0, idex_bubble}, 32'd0);
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i]);
            e.e_frz = vecs[i].e_frz; e.e_fl = vecs[i].e_fl; e.e_bub = vecs[i].e_bub;
            e.e_st = vecs[i].e_st; e.idx = i;
            sb.push_back(e);
            @(negedge clk);
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk($sformatf("v%0d_freeze", e.idx), {31'd0, freeze}, {31'd0, e.e_frz});
                chk($sformatf("v%0d_flush", e.idx), {31'd0, ifid_flush}, {31'd0, e.e_fl});
                chk($sformatf("v%0d_bubble", e.idx), {31'd0, idex_bubble}, {31'd0, e.e_bub});
                chk($sformatf("v%0d_state", e.idx), {30'd0, state}, {30'd0, e.e_st});
            end
            @(posedge clk); #1;
        end
        chk("tbl_stall_cnt", {16'd0, stall_cnt}, NF ? 32'd4 : 32'd2);
        chk("tbl_flush_cnt", {16'd0, flush_cnt}, 32'd4);

        // Branch with an active hazard: two flush cycles, never a freeze.
        do_reset();
        load_use(1'b1);
        @(negedge clk);
        chk("br1_freeze", {31'd0, freeze}, 32'd0);
        chk("br1_flush", {31'd0, ifid_flush}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("br2_state", {30'd0, state}, 32'd2);
        chk("br2_freeze", {31'd0, freeze}, 32'd0);
        chk("br2_flush", {31'd0, ifid_flush}, 32'd1);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        chk("br3_flush", {31'd0, ifid_flush}, 32'd0);
        chk("br_flush_cnt", {16'd0, flush_cnt}, 32'd2);
        chk("br_stall_cnt", {16'd0, stall_cnt}, 32'd0);

        // Asynchronous reset in the middle of FLUSH.
        do_reset();
        load_use(1'b1);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        chk("midfl_state", {30'd0, state}, 32'd2);
        #1 rst = 1'b1;
        #1;
        chk("arst_flush", {31'd0, ifid_flush}, 32'd0);
        chk("arst_bubble", {31'd0, idex_bubble}, 32'd0);
        chk("arst_state", {30'd0, state}, 32'd0);
        chk("arst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
        chk("arst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Saturation of the stall counter.
        load_use(1'b0);
        repeat (65534) @(posedge clk);
        #1;
        chk("sat_pre", {16'd0, stall_cnt}, 32'h0000FFFE);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk($sformatf("sat_%0d", k), {16'd0, stall_cnt}, 32'h0000FFFF);
        end
        chk("sat_state", {30'd0, state}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
